// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared encodings for the bus-to-UART transmit bridge.
//   bus_state_t  - bus deserialiser FSM states (also exported on state_out)
//   ser_state_t  - UART serialiser bit FSM states
//   REG_*        - register select values decoded from the low address bits
//   CTRL_*       - bit positions inside the control register
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        B_IDLE   = 3'd0,
        B_SHIFT  = 3'd1,
        B_DECODE = 3'd2,
        B_BURST  = 3'd3
    } bus_state_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } ser_state_t;

    localparam int REG_TX   = 0;
    localparam int REG_CTRL = 1;

    localparam int CTRL_PAR_EN   = 0;
    localparam int CTRL_PAR_ODD  = 1;
    localparam int CTRL_TWO_STOP = 2;
    localparam int CTRL_CLR_OVF  = 7;

endpackage

// File: rtl/uart_tx_fifo_bridge_if.sv
// uart_tx_fifo_bridge_if: bit-serial bus frame signals.
//   validIn  - frame strobe, high for every bit cycle of a frame
//   wren     - write qualifier, meaningful on the first frame cycle
//   Address  - serial address, MSB first
//   DataIn   - serial data, MSB first
//   BurstEn  - keep the latched address for further data-only frames
//   ready    - slave can take a whole frame
interface uart_tx_fifo_bridge_if;
    logic validIn;
    logic wren;
    logic Address;
    logic DataIn;
    logic BurstEn;
    logic ready;

    modport master (output validIn, wren, Address, DataIn, BurstEn, input ready);
    modport slave  (input validIn, wren, Address, DataIn, BurstEn, output ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: baud counter plus bit FSM for one UART character.
//   clk, reset    - clock, synchronous active-high reset
//   valid_i       - FIFO has a character
//   data_i        - FIFO head
//   cts_i         - clear-to-send, checked only when a character starts
//   parity_en_i / parity_odd_i / two_stop_i - framing, captured at pop
//   pop_o         - consume FIFO head this cycle
//   tx_o          - serial line (idles high)
//   busy_o        - high from the pop cycle through the last stop-bit cycle
module uart_tx_serializer
    import uart_bridge_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [N-1:0] data_i,
    input  logic         cts_i,
    input  logic         parity_en_i,
    input  logic         parity_odd_i,
    input  logic         two_stop_i,
    output logic         pop_o,
    output logic         tx_o,
    output logic         busy_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N);

    ser_state_t     state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   sh_q, sh_d;
    logic           par_q, par_d, pen_q, pen_d, two_q, two_d;
    logic           last, load;

    assign last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            two_q   <= two_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pen_d   = pen_q;
        two_d   = two_q;
        load    = 1'b0;
        tx_o    = 1'b1;

        if (state_q != S_IDLE)
            baud_d = last ? '0 : baud_q + 1'b1;

        case (state_q)
            S_IDLE: load = valid_i & cts_i;
            S_START: begin
                tx_o = 1'b0;
                if (last) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_o = sh_q[0];
                if (last) begin
                    sh_d = {1'b0, sh_q[N-1:1]};
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                tx_o = par_q;
                if (last) state_d = S_STOP;
            end
            S_STOP: begin
                // idx counts stop bits; the final stop cycle doubles as the
                // pop cycle of the next character so there is no idle gap.
                if (last) begin
                    if (two_q && idx_q == '0) idx_d = IW'(1);
                    else if (valid_i && cts_i) load = 1'b1;
                    else state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_START;
            baud_d  = '0;
            idx_d   = '0;
            sh_d    = data_i;
            par_d   = (^data_i) ^ parity_odd_i;
            pen_d   = parity_en_i;
            two_d   = two_stop_i;
        end
    end

    assign pop_o  = load;
    assign busy_o = (state_q != S_IDLE) | load;

endmodule

// File: rtl/uart_tx_fifo_bridge.sv
// uart_tx_fifo_bridge: bit-serial bus slave feeding a TX FIFO and control
// register, drained by a UART serialiser.
//   clk, reset  - clock, synchronous active-high reset
//   bus         - serial bus frame signals (slave side)
//   cts         - clear-to-send from the far end
//   tx, busy    - UART line and serialiser activity
//   fifo_count  - FIFO occupancy
//   overflow    - sticky dropped-write flag, cleared by ctrl bit 7
//   state_out   - bus FSM state for debug
module uart_tx_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int N            = 8,
    parameter int ADN          = 12,
    parameter int MemN         = 2,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int SLAVE_ID     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_fifo_bridge_if.slave     bus,
    input  logic                     cts,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [2:0]               state_out
);
    localparam int L       = (ADN > N) ? ADN : N;
    localparam int CW      = $clog2(L + 1);
    localparam int AW      = $clog2(DEPTH);
    localparam int CLR_IDX = (N >= 8) ? CTRL_CLR_OVF : 0;

    // ---------------- bus deserialiser ----------------
    bus_state_t      bst_q, bst_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ADN-1:0]  addr_q, addr_d;
    logic [N-1:0]    data_q, data_d;
    logic [MemN-1:0] sel_q, sel_d;
    logic            match_q, match_d, bpush_q, bpush_d;

    logic            dec_match, in_dec, wr_v, push_req, ctrl_we;
    logic [MemN-1:0] dec_sel, wr_s;

    assign dec_match = (addr_q[ADN-1:MemN] == (ADN - MemN)'(SLAVE_ID));
    assign dec_sel   = addr_q[MemN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            bst_q   <= B_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            match_q <= 1'b0;
            bpush_q <= 1'b0;
        end else begin
            bst_q   <= bst_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            match_q <= match_d;
            bpush_q <= bpush_d;
        end
    end

    always_comb begin
        bst_d   = bst_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        match_d = match_q;
        bpush_d = 1'b0;
        case (bst_q)
            B_IDLE: begin
                // the first frame bit is captured on the strobe cycle itself
                if (bus.validIn && bus.wren) begin
                    addr_d = {addr_q[ADN-2:0], bus.Address};
                    data_d = {data_q[N-2:0], bus.DataIn};
                    cnt_d  = CW'(1);
                    bst_d  = B_SHIFT;
                end
            end
            B_SHIFT: begin
                if (!bus.validIn) begin
                    cnt_d = '0;
                    bst_d = B_IDLE;
                end else begin
                    if (cnt_q < CW'(ADN)) addr_d = {addr_q[ADN-2:0], bus.Address};
                    if (cnt_q < CW'(N))   data_d = {data_q[N-2:0], bus.DataIn};
                    if (cnt_q == CW'(L - 1)) begin
                        cnt_d = '0;
                        bst_d = B_DECODE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            B_DECODE: begin
                sel_d   = dec_sel;
                match_d = dec_match;
                bst_d   = bus.BurstEn ? B_BURST : B_IDLE;
            end
            B_BURST: begin
                if (bus.validIn) begin
                    data_d = {data_q[N-2:0], bus.DataIn};
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        bpush_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // a partial burst frame is discarded when validIn drops
                    cnt_d = '0;
                    if (!bus.BurstEn) bst_d = B_IDLE;
                end
            end
            default: bst_d = B_IDLE;
        endcase
    end

    // Writes come from DECODE (live address) or one cycle after a burst frame
    // (latched select); the two never coincide.
    assign in_dec   = (bst_q == B_DECODE);
    assign wr_v     = (in_dec && dec_match) || (bpush_q && match_q);
    assign wr_s     = in_dec ? dec_sel : sel_q;
    assign push_req = wr_v && (wr_s == MemN'(REG_TX));
    assign ctrl_we  = wr_v && (wr_s == MemN'(REG_CTRL));

    // ---------------- TX FIFO + ctrl ----------------
    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic [2:0]    ctrl_q;
    logic          overflow_q, full, empty, do_push, pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_req && !full;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ctrl_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            case ({do_push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ctrl_we) begin
                ctrl_q <= data_q[CTRL_TWO_STOP:CTRL_PAR_EN];
                if ((N >= 8) && data_q[CLR_IDX]) overflow_q <= 1'b0;
            end
            if (push_req && full) overflow_q <= 1'b1;
        end
    end

    uart_tx_serializer #(
        .N            (N),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (!empty),
        .data_i       (mem_q[rptr_q]),
        .cts_i        (cts),
        .parity_en_i  (ctrl_q[CTRL_PAR_EN]),
        .parity_odd_i (ctrl_q[CTRL_PAR_ODD]),
        .two_stop_i   (ctrl_q[CTRL_TWO_STOP]),
        .pop_o        (pop),
        .tx_o         (tx),
        .busy_o       (busy)
    );

    assign bus.ready  = ((bst_q == B_IDLE) || (bst_q == B_BURST)) && !full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign state_out  = bst_q;

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// Bench for uart_tx_fifo_bridge: N=8, ADN=12, MemN=2, DEPTH=16,
// CLKS_PER_BIT=4, SLAVE_ID=0. A table of {ctrl, data, expected tx bit
// sequence} vectors plus hand-written burst/overflow, address-miss, abort
// and mid-character reset sequences.
module tb_uart_tx_fifo_bridge;
    import uart_bridge_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset, cts;
    logic       tx, busy, overflow;
    logic [4:0] fifo_count;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_bridge_if bus();

    uart_tx_fifo_bridge #(
        .N(8), .ADN(12), .MemN(2), .DEPTH(16), .CLKS_PER_BIT(CPB), .SLAVE_ID(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .cts(cts), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctrl;
        logic [7:0]  data;
        logic [11:0] seq;    // tx bits in time order, first bit at seq[nbits-1]
        int          nbits;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_frame(input logic [11:0] addr, input logic [7:0] data, input logic burst);
        for (int i = 0; i < 12; i++) begin
            bus.validIn = 1'b1;
            bus.wren    = (i == 0);
            bus.Address = addr[11-i];
            if (i < 8) bus.DataIn = data[7-i];
            else       bus.DataIn = 1'b0;
            bus.BurstEn = burst;
            tick();
        end
        bus.validIn = 1'b0;
        bus.wren    = 1'b0;
        bus.Address = 1'b0;
        bus.DataIn  = 1'b0;
        tick();
    endtask

    task automatic burst_data(input logic [7:0] data);
        for (int i = 0; i < 8; i++) begin
            bus.validIn = 1'b1;
            bus.DataIn  = data[7-i];
            tick();
        end
        bus.validIn = 1'b0;
        bus.DataIn  = 1'b0;
        tick();
    endtask

    // leaves the caller at the negedge of the first start-bit cycle
    task automatic wait_start(input string tag);
        int n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s start", tag), 32'(tx), 32'h0);
    endtask

    // every cycle of every bit is compared, so bit length is enforced too
    task automatic check_char(input logic [11:0] seq, input int nbits, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s bit%0d cyc%0d", tag, b, c), 32'(tx), 32'(seq[nbits-1-b]));
                if (c == 0) check($sformatf("%s busy bit%0d", tag, b), 32'(busy), 32'h1);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] seq;
        logic [7:0]  dv;

        vecs[0] = '{8'h00, 8'hA5, 12'b000101001011, 10};
        vecs[1] = '{8'h03, 8'hA5, 12'b001010010111, 11};
        vecs[2] = '{8'h05, 8'hA5, 12'b010100101011, 12};
        vecs[3] = '{8'h00, 8'h3C, 12'b000001111001, 10};
        vecs[4] = '{8'h01, 8'h07, 12'b001110000011, 11};
        vecs[5] = '{8'h07, 8'h00, 12'b000000000111, 12};

        reset = 1'b1;
        cts = 1'b0;
        bus.validIn = 1'b0; bus.wren = 1'b0; bus.Address = 1'b0;
        bus.DataIn = 1'b0; bus.BurstEn = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst tx", 32'(tx), 32'h1);
        check("rst busy", 32'(busy), 32'h0);
        check("rst ready", 32'(bus.ready), 32'h1);
        check("rst count", 32'(fifo_count), 32'h0);
        check("rst overflow", 32'(overflow), 32'h0);
        check("rst state", 32'(state_out), 32'(B_IDLE));

        // ---- table: ctrl write, data write, then check the whole character
        for (int i = 0; i < 6; i++) begin
            cts = 1'b0;
            bus_frame(12'h001, vecs[i].ctrl, 1'b0);
            bus_frame(12'h000, vecs[i].data, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d count1", i), 32'(fifo_count), 32'h1);
            check($sformatf("v%0d idle tx", i), 32'(tx), 32'h1);
            cts = 1'b1;
            wait_start($sformatf("v%0d", i));
            cts = 1'b0;  // must not truncate the character in flight
            check_char(vecs[i].seq, vecs[i].nbits, $sformatf("v%0d", i));
            check($sformatf("v%0d end tx", i), 32'(tx), 32'h1);
            check($sformatf("v%0d end busy", i), 32'(busy), 32'h0);
            check($sformatf("v%0d count0", i), 32'(fifo_count), 32'h0);
        end

        // ---- clear ctrl, burst-fill the FIFO with cts low, then overflow
        bus_frame(12'h001, 8'h00, 1'b0);
        bus_frame(12'h000, 8'h00, 1'b1);
        @(negedge clk);
        check("burst state", 32'(state_out), 32'(B_BURST));
        check("burst ready", 32'(bus.ready), 32'h1);
        for (int d = 1; d < 16; d++) burst_data(8'(d));
        @(negedge clk);
        check("full count", 32'(fifo_count), 32'd16);
        check("full ready", 32'(bus.ready), 32'h0);
        check("full no ovf", 32'(overflow), 32'h0);
        burst_data(8'h10);
        @(negedge clk);
        check("ovf set", 32'(overflow), 32'h1);
        check("ovf count", 32'(fifo_count), 32'd16);
        bus.BurstEn = 1'b0;
        tick();
        check("burst exit", 32'(state_out), 32'(B_IDLE));

        cts = 1'b1;
        wait_start("stream");
        for (int d = 0; d < 16; d++) begin
            dv = 8'(d);
            seq = '0;
            for (int k = 0; k < 8; k++) seq[8-k] = dv[k];
            seq[0] = 1'b1;
            check_char(seq, 10, $sformatf("stream%0d", d));
        end
        check("stream end tx", 32'(tx), 32'h1);
        check("stream end busy", 32'(busy), 32'h0);
        check("stream count", 32'(fifo_count), 32'h0);
        check("ovf sticky", 32'(overflow), 32'h1);

        cts = 1'b0;
        bus_frame(12'h001, 8'h80, 1'b0);
        @(negedge clk);
        check("ovf clear", 32'(overflow), 32'h0);

        // ---- non-matching address: no push, no ctrl change
        bus_frame({10'd5, 2'd0}, 8'h55, 1'b0);
        @(negedge clk);
        check("miss count", 32'(fifo_count), 32'h0);
        check("miss state", 32'(state_out), 32'(B_IDLE));
        bus_frame({10'd5, 2'd1}, 8'h07, 1'b0);
        bus_frame(12'h000, 8'h3C, 1'b0);
        @(negedge clk);
        check("miss push", 32'(fifo_count), 32'h1);
        cts = 1'b1;
        wait_start("miss");
        check_char(12'b000001111001, 10, "miss ctrl");

        // ---- frame aborted after 5 of 12 cycles, then immediate new frame
        cts = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.validIn = 1'b1;
            bus.wren    = (i == 0);
            bus.Address = 1'b0;
            bus.DataIn  = 1'b1;
            tick();
        end
        @(negedge clk);
        check("abort mid state", 32'(state_out), 32'(B_SHIFT));
        bus.validIn = 1'b0;
        bus.wren    = 1'b0;
        bus.DataIn  = 1'b0;
        tick();
        check("abort state", 32'(state_out), 32'(B_IDLE));
        check("abort count", 32'(fifo_count), 32'h0);
        bus_frame(12'h000, 8'h3C, 1'b0);
        @(negedge clk);
        check("after abort count", 32'(fifo_count), 32'h1);
        cts = 1'b1;
        wait_start("abort");
        check_char(12'b000001111001, 10, "after abort");

        // ---- reset in the middle of a data bit
        cts = 1'b0;
        bus_frame(12'h000, 8'hA5, 1'b0);
        bus_frame(12'h000, 8'h3C, 1'b0);
        @(negedge clk);
        check("pre rst count", 32'(fifo_count), 32'h2);
        cts = 1'b1;
        wait_start("midrst");
        repeat (6) @(negedge clk);
        check("midrst in data", 32'(tx), 32'h1);  // data bit 0 of 0xA5
        reset = 1'b1;
        @(negedge clk);
        check("midrst tx", 32'(tx), 32'h1);
        check("midrst busy", 32'(busy), 32'h0);
        check("midrst count", 32'(fifo_count), 32'h0);
        check("midrst state", 32'(state_out), 32'(B_IDLE));
        reset = 1'b0;
        cts = 1'b0;
        tick();
        bus_frame(12'h000, 8'hA5, 1'b0);
        @(negedge clk);
        check("post rst count", 32'(fifo_count), 32'h1);
        cts = 1'b1;
        wait_start("postrst");
        check_char(vecs[0].seq, vecs[0].nbits, "post rst");
        check("post rst busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_bridge.md
Name: uart_tx_fifo_bridge

Overview:
Parametrised successor of the bus-to-UART transmit path. It is a bit-serial bus slave that deserialises write frames into a TX FIFO and a control register. A single serialiser drains the FIFO onto the tx line with runtime-selectable parity, 1/2 stop bits and CTS flow control. It sits on the external-communication branch of the system bus, alongside the other serial slaves.

Parameters:
N, 8, data bits per bus frame and per UART character (5..9)
ADN, 12, bus address frame length in bits
MemN, 2, low address bits decoded as register select
DEPTH, 16, TX FIFO entries (power of two, >=2)
CLKS_PER_BIT, 868, clk cycles per UART bit (>=2)
SLAVE_ID, 0, value of Address[ADN-1:MemN] this slave answers to

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
validIn  in  1  bus frame strobe; high for every bit cycle of a frame
wren  in  1  write qualifier, sampled on first frame cycle
Address  in  1  serial address, MSB first, first ADN cycles of a frame
DataIn  in  1  serial data, MSB first, first N cycles of a frame (parallel with Address)
BurstEn  in  1  held high: further N-bit data frames reuse the latched address
cts  in  1  clear-to-send from far end, active high
ready  out  1  slave can accept a full frame (idle and FIFO not full)
tx  out  1  UART line, idles high
busy  out  1  serialiser mid-character
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: write to full FIFO dropped; cleared by ctrl write bit 7
state_out  out  3  bus FSM state encoding for debug

Behaviour:
- Reset: tx=1, busy=0, ready=1, fifo_count=0, overflow=0, state_out=IDLE, ctrl=0 (no parity, 1 stop). Reset mid-character aborts at once; tx=1 on the next cycle; FIFO contents are discarded.
- Bus FSM states: IDLE, SHIFT, DECODE, BURST.
  - IDLE -> SHIFT on validIn&wren, taking the first bit on that same cycle.
  - SHIFT runs max(ADN,N) cycles. Address and DataIn are shifted in parallel.
  - DECODE (1 cycle): on an address match, reg select 0 pushes data into the FIFO. Select 1 writes ctrl[N-1:0]: bit0 parity_en, bit1 parity_odd, bit2 two_stop, bit7 (N>=8) clears overflow. Other selects and non-matching addresses are ignored.
  - DECODE -> BURST if BurstEn, else IDLE.
  - BURST: each new validIn run of N cycles is a data-only frame to the latched select, pushed at the following cycle. BurstEn low while validIn is low -> IDLE.
- validIn dropping mid-SHIFT aborts the frame: no write, return to IDLE.
- ready=0 outside IDLE/BURST and whenever the FIFO is full.
- Push on full is dropped, sets overflow, and fifo_count is unchanged. Push and pop on the same cycle are both legal; the count is unchanged.
- Serialiser start: idle & FIFO non-empty & cts=1 -> pop on cycle t; tx=0 (start bit) from t+1.
- Character order: start, N data bits LSB first, optional parity (even: XOR of the data; odd: its inverse), 1 or 2 stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- ctrl is sampled at pop; a mid-character change affects the next character only.
- cts is checked only at character start; deassertion mid-character never truncates it.
- busy=1 from the pop cycle through the last stop-bit cycle. Back-to-back characters have no idle gap.
- Pointer wrap modulo DEPTH; full when count==DEPTH.

Decomposition:
- Package uart_bridge_pkg holds the bus FSM state encodings, serialiser state encodings (IDLE, START, DATA, PARITY, STOP), register-select constants (REG_TX=0, REG_CTRL=1) and ctrl bit positions.
- Sub-module uart_tx_serializer (params N, CLKS_PER_BIT): baud counter plus bit FSM, with a pop/valid handshake to the FIFO.
- The FIFO is inline in the top level.

Test Plan:
- Reset, then write 0xA5 to REG_TX, N=8, CLKS_PER_BIT=4, cts=1 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy falls after the stop bit; fifo_count 1 -> 0.
- Write ctrl=0x03 (odd parity), then 0xA5 -> parity bit 1 before the stop bit. With ctrl=0x05 (even parity, 2 stop) -> parity 0 and 8 cycles of stop.
- cts=0, burst-write 16 bytes 0x00..0x0F -> fifo_count=16, ready=0. A 17th write -> dropped, overflow=1. Raise cts -> 16 characters in order with no gaps.
- Address with a non-matching SLAVE_ID -> no FIFO push, no ctrl change, FSM back to IDLE.
- validIn dropped after 5 of 12 cycles -> no write; an immediate new frame 0x3C is accepted correctly.
- reset asserted mid-data-bit -> tx=1 next cycle, fifo_count=0, busy=0. A subsequent write transmits normally.
